// File: rtl/rf_writeback_if.sv
// ALU result handshake into the write-back stage.
// The producer holds every field stable while i_alu_valid=1 until it sees i_alu_valid & o_alu_ready.
interface rf_writeback_if #(
    parameter int AW = 4
);
    logic          i_alu_valid;
    logic          o_alu_ready;
    logic [AW-1:0] i_alu_rd;
    logic [3:0]    i_alu_wen;
    logic [31:0]   i_alu_data;

    modport master (
        output i_alu_valid, i_alu_rd, i_alu_wen, i_alu_data,
        input  o_alu_ready
    );

    modport slave (
        input  i_alu_valid, i_alu_rd, i_alu_wen, i_alu_data,
        output o_alu_ready
    );
endinterface

// File: rtl/rf_writeback.sv
// Write-back stage: merges load responses (never stalled) and ALU results (skid FIFO) onto
// the single register-file write port, and keeps the per-register pending-load scoreboard.
module rf_writeback #(
    parameter int ALU_FIFO_DEPTH = 2,
    parameter int NREGS          = 16,
    localparam int AW            = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    rf_writeback_if.slave    alu,
    input  logic             i_ld_issue,
    input  logic [AW-1:0]    i_ld_issue_rd,
    input  logic             i_ld_valid,
    input  logic [AW-1:0]    i_ld_rd,
    input  logic [1:0]       i_ld_size,
    input  logic             i_ld_signed,
    input  logic [1:0]       i_ld_boff,
    input  logic [31:0]      i_ld_data,
    output logic [AW-1:0]    o_waddr,
    output logic [3:0]       o_wen,
    output logic             o_cs_b,
    output logic [31:0]      o_din,
    output logic [NREGS-1:0] o_pending,
    output logic             o_ld_err
);
    localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam int CW = $clog2(ALU_FIFO_DEPTH + 1);

    logic [AW-1:0]    fifo_rd_q   [ALU_FIFO_DEPTH];
    logic [AW-1:0]    fifo_rd_d   [ALU_FIFO_DEPTH];
    logic [3:0]       fifo_wen_q  [ALU_FIFO_DEPTH];
    logic [3:0]       fifo_wen_d  [ALU_FIFO_DEPTH];
    logic [31:0]      fifo_data_q [ALU_FIFO_DEPTH];
    logic [31:0]      fifo_data_d [ALU_FIFO_DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             alu_ready_q, alu_ready_d;

    logic [AW-1:0]    waddr_q, waddr_d;
    logic [3:0]       wen_q, wen_d;
    logic             cs_b_q, cs_b_d;
    logic [31:0]      din_q, din_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             ld_err_q, ld_err_d;

    logic             alu_keep;
    logic             push;
    logic             pop;
    logic [15:0]      ld_shifted;
    logic [31:0]      ld_fmt;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(ALU_FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    // Half loads with odd offsets use the same shift as aligned ones; only the low 16 bits matter.
    always_comb begin
        ld_shifted = 16'(i_ld_data >> {i_ld_boff, 3'b000});
        case (i_ld_size)
            2'b00:   ld_fmt = {{24{i_ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            2'b01:   ld_fmt = {{16{i_ld_signed & ld_shifted[15]}}, ld_shifted};
            default: ld_fmt = i_ld_data;
        endcase
    end

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_wen_d  = fifo_wen_q;
        fifo_data_d = fifo_data_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        waddr_d     = waddr_q;
        wen_d       = wen_q;
        cs_b_d      = cs_b_q;
        din_d       = din_q;
        pending_d   = pending_q;
        ld_err_d    = ld_err_q;
        push        = 1'b0;
        pop         = 1'b0;

        // An all-zero byte mask is accepted by the handshake but produces no write at all.
        alu_keep = i_clk_en & alu.i_alu_valid & alu_ready_q & (|alu.i_alu_wen);

        if (i_clk_en) begin
            cs_b_d = 1'b1;
            wen_d  = 4'b0000;
            if (i_ld_valid) begin
                cs_b_d  = 1'b0;
                waddr_d = i_ld_rd;
                wen_d   = 4'b1111;
                din_d   = ld_fmt;
                push    = alu_keep;
            end else if (count_q != '0) begin
                cs_b_d  = 1'b0;
                waddr_d = fifo_rd_q[rd_ptr_q];
                wen_d   = fifo_wen_q[rd_ptr_q];
                din_d   = fifo_data_q[rd_ptr_q];
                pop     = 1'b1;
                push    = alu_keep;
            end else if (alu_keep) begin
                cs_b_d  = 1'b0;
                waddr_d = alu.i_alu_rd;
                wen_d   = alu.i_alu_wen;
                din_d   = alu.i_alu_data;
            end

            // Clear before set so a same-cycle issue to the written register stays pending.
            if (i_ld_valid) begin
                pending_d[i_ld_rd] = 1'b0;
                if (!pending_q[i_ld_rd]) begin
                    ld_err_d = 1'b1;
                end
            end
            if (i_ld_issue) begin
                pending_d[i_ld_issue_rd] = 1'b1;
            end
        end

        if (push) begin
            fifo_rd_d[wr_ptr_q]   = alu.i_alu_rd;
            fifo_wen_d[wr_ptr_q]  = alu.i_alu_wen;
            fifo_data_d[wr_ptr_q] = alu.i_alu_data;
            wr_ptr_d              = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        // Ready was high when a push happened, so the FIFO had room even without a pop.
        count_d     = count_q + CW'(push) - CW'(pop);
        alu_ready_d = (count_d < CW'(ALU_FIFO_DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < ALU_FIFO_DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_wen_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            alu_ready_q <= 1'b1;
            waddr_q     <= '0;
            wen_q       <= 4'b0000;
            cs_b_q      <= 1'b1;
            din_q       <= '0;
            pending_q   <= '0;
            ld_err_q    <= 1'b0;
        end else begin
            fifo_rd_q   <= fifo_rd_d;
            fifo_wen_q  <= fifo_wen_d;
            fifo_data_q <= fifo_data_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            alu_ready_q <= alu_ready_d;
            waddr_q     <= waddr_d;
            wen_q       <= wen_d;
            cs_b_q      <= cs_b_d;
            din_q       <= din_d;
            pending_q   <= pending_d;
            ld_err_q    <= ld_err_d;
        end
    end

    assign alu.o_alu_ready = alu_ready_q;
    assign o_waddr         = waddr_q;
    assign o_wen           = wen_q;
    assign o_cs_b          = cs_b_q;
    assign o_din           = din_q;
    assign o_pending       = pending_q;
    assign o_ld_err        = ld_err_q;
endmodule

// File: doc/rf_writeback.md
Name: rf_writeback

Overview:
Write-back stage feeding the 16x32 one-write/two-read register file write port (waddr, byte write enables, active-low chip select, write data). It merges two producers onto that single port: ALU results, which can be stalled, and memory load responses, which cannot. Load data is aligned and extended before the write. A per-register pending-load scoreboard is maintained for operand-hazard detection upstream.

Parameters:
ALU_FIFO_DEPTH, 2, ALU result skid FIFO entries (>=1)
NREGS, 16, register count; sets scoreboard width and address width log2(NREGS)=4

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_clk_en  in  1  global clock enable; state advances only when 1
i_alu_valid  in  1  ALU result offered
o_alu_ready  out  1  ALU result accepted this cycle when valid&ready
i_alu_rd  in  4  ALU destination register
i_alu_wen  in  4  ALU byte-lane write enables, bit n = bits 8n+7:8n
i_alu_data  in  32  ALU result
i_ld_issue  in  1  load issued to memory this cycle
i_ld_issue_rd  in  4  destination of issued load
i_ld_valid  in  1  load response present; no backpressure
i_ld_rd  in  4  load destination register
i_ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
i_ld_signed  in  1  sign-extend byte/half
i_ld_boff  in  2  byte offset within the 32-bit word
i_ld_data  in  32  raw memory word
o_waddr  out  4  register file write address
o_wen  out  4  register file byte write enables, active-high
o_cs_b  out  1  register file select, active-low; 0 = write this cycle
o_din  out  32  register file write data
o_pending  out  16  bit r set = load to r outstanding
o_ld_err  out  1  sticky: load response to a non-pending register

Behaviour:
- Reset: o_cs_b=1, o_wen=0, o_waddr=0, o_din=0, o_pending=0, o_ld_err=0, FIFO empty, o_alu_ready=1. Reset applies on the i_clk edge regardless of i_clk_en.
- i_clk_en=0: all registers hold, outputs included. No acceptance: ALU handshake counts only when i_clk_en=1. Upstream guarantees i_ld_valid/i_ld_issue are asserted only with i_clk_en=1.
- Output stage is fully registered. A write selected in enabled cycle N appears on o_* after edge N, with o_cs_b=0 for exactly one enabled cycle. Latency = 1 cycle.
- Arbitration per enabled cycle, strict priority:
  1) i_ld_valid: write the load.
  2) FIFO non-empty: write the FIFO head and dequeue.
  3) i_alu_valid & o_alu_ready: write the ALU input directly; FIFO bypassed, stays empty.
  4) Otherwise o_cs_b=1, o_wen=0; o_waddr/o_din hold.
- An ALU result accepted but not written that cycle (cases 1, 2) is enqueued. This preserves ALU order.
- o_alu_ready = (FIFO count < ALU_FIFO_DEPTH), registered from post-edge count. When full, no enqueue even if a dequeue occurs the same cycle.
- ALU result with i_alu_wen=0000 is accepted and discarded: no write, no FIFO entry.
- ALU write: o_wen=i_alu_wen, o_din=i_alu_data unchanged; unselected lanes must be preserved by the register file.
- Load formatting: s = i_ld_data >> (8*i_ld_boff).
  - Byte: s[7:0] extended to 32 bits.
  - Half: s[15:0] extended; boff must be 0 or 2, with boff 1 or 3 using the same shift.
  - Word: boff ignored.
  - Extension is zero unless i_ld_signed. o_wen=1111.
- Scoreboard: i_ld_issue sets bit i_ld_issue_rd. A load written (case 1) clears bit i_ld_rd. A set and clear of the same register in the same cycle leaves it set. o_pending is the registered state, updated with the write.
- Load response with o_pending[i_ld_rd]=0: still written; o_ld_err set, held until reset.
- Ordering between ALU and load to the same register is enforced upstream via o_pending; this block only applies the priority above.
- Reset mid-operation: FIFO contents and pending bits discarded; no write emitted on the reset edge or the following cycle.

Test Plan:
- Reset then idle -> o_cs_b=1, o_wen=0, o_pending=0, o_alu_ready=1.
- ALU valid rd=3, wen=1111, data=0x12345678, no load -> next cycle o_cs_b=0, o_waddr=3, o_wen=1111, o_din=0x12345678; following cycle o_cs_b=1.
- Issue load rd=5, then response size=byte, signed, boff=2, data=0x00F40000 -> write R5 with 0xFFFFFFF4, wen=1111. o_pending[5] is 1 between issue and write, 0 after.
- Loads valid 3 consecutive cycles with ALU valid each cycle (rd 1,2,3):
  - ALU 1 and 2 accepted, o_alu_ready drops after the 2nd.
  - The 3 loads are written first, then ALU rd1, then rd2, in order.
  - ALU rd3 accepted once ready returns.
- Load response to rd=7 never issued -> R7 written, o_ld_err=1 until i_rst. Issue and writeback to rd=4 in the same cycle -> o_pending[4] remains 1.
- i_clk_en=0 for 3 cycles with writes pending -> outputs and FIFO frozen; sequence resumes unchanged when i_clk_en returns to 1.
